// File: rtl/fir_mac_engine.sv
// Sequential-MAC FIR engine: coefficient RAM, circular sample history, one signed MAC per clock.
// Define FIR_SAT_EN to saturate the result to OUT_W and add the sat_flag_o output.
module fir_mac_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 64,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    coef_we_i,
    input  logic [$clog2(TAPS)-1:0] coef_addr_i,
    input  logic [COEF_W-1:0]       coef_wdata_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_W-1:0]       s_data_i,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [OUT_W-1:0]        m_data_o,
`ifdef FIR_SAT_EN
    output logic                    sat_flag_o,
`endif
    output logic                    busy_o
);

    localparam int PTR_W  = $clog2(TAPS);
    localparam int CNT_W  = $clog2(TAPS + 1);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(TAPS);
`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);
`endif

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_q;
    logic signed [COEF_W-1:0]  coefMem [TAPS];
    logic signed [DATA_W-1:0]  histMem [TAPS];
    logic [PTR_W-1:0]          wrPtr_q;
    logic [PTR_W-1:0]          rdPtr_q;
    logic [PTR_W-1:0]          tap_q;
    logic [CNT_W-1:0]          fill_q;
    logic                      issue_q;
    logic                      prodValid_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic                      sReady_q;
    logic                      mValid_q;
    logic                      busy_q;
    logic [OUT_W-1:0]          mData_q;
    logic [OUT_W-1:0]          result_d;
    logic                      accept;
    logic                      coefWrite;
    logic                      tapLive;
`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0]   shifted_d;
    logic                      sat_d;
    logic                      satFlag_q;
`endif

    // Taps beyond the number of samples seen since reset read as zero, hiding stale history.
    always_comb begin
        accept    = s_valid_i && sReady_q;
        coefWrite = coef_we_i && (state_q == IDLE) && ({1'b0, coef_addr_i} < (PTR_W + 1)'(TAPS));
        tapLive   = CNT_W'(tap_q) <= fill_q;
        prod_d    = '0;
        if (tapLive) begin
            prod_d = PROD_W'(coefMem[tap_q]) * PROD_W'(histMem[rdPtr_q]);
        end
        acc_d = acc_q;
        if (prodValid_q) begin
            acc_d = acc_q + ACC_W'(prod_q);
        end
`ifdef FIR_SAT_EN
        shifted_d = acc_d >>> SHIFT;
        result_d  = shifted_d[OUT_W-1:0];
        sat_d     = 1'b0;
        if (shifted_d > OUT_MAX) begin
            result_d = OUT_MAX[OUT_W-1:0];
            sat_d    = 1'b1;
        end else if (shifted_d < OUT_MIN) begin
            result_d = OUT_MIN[OUT_W-1:0];
            sat_d    = 1'b1;
        end
`else
        result_d = OUT_W'(acc_d >>> SHIFT);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (coefWrite) begin
            coefMem[coef_addr_i] <= coef_wdata_i;
        end
        if (accept) begin
            histMem[wrPtr_q] <= s_data_i;
        end
    end

    // Products are registered, so the final accumulate lands one clock after the last tap is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            tap_q       <= '0;
            fill_q      <= '0;
            issue_q     <= 1'b0;
            prodValid_q <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            sReady_q    <= 1'b0;
            mValid_q    <= 1'b0;
            busy_q      <= 1'b0;
            mData_q     <= '0;
`ifdef FIR_SAT_EN
            satFlag_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= MAC;
                        sReady_q    <= 1'b0;
                        busy_q      <= 1'b1;
                        acc_q       <= '0;
                        tap_q       <= '0;
                        rdPtr_q     <= wrPtr_q;
                        issue_q     <= 1'b1;
                        prodValid_q <= 1'b0;
                    end else begin
                        sReady_q <= 1'b1;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (issue_q) begin
                        prod_q      <= prod_d;
                        prodValid_q <= 1'b1;
                        if (tap_q == LAST_TAP) begin
                            issue_q <= 1'b0;
                        end else begin
                            tap_q   <= tap_q + PTR_W'(1);
                            rdPtr_q <= (rdPtr_q == '0) ? LAST_TAP : rdPtr_q - PTR_W'(1);
                        end
                    end else begin
                        prodValid_q <= 1'b0;
                    end
                    if (prodValid_q && !issue_q) begin
                        state_q  <= OUT;
                        mValid_q <= 1'b1;
                        mData_q  <= result_d;
`ifdef FIR_SAT_EN
                        satFlag_q <= sat_d;
`endif
                        wrPtr_q  <= (wrPtr_q == LAST_TAP) ? '0 : wrPtr_q + PTR_W'(1);
                        if (fill_q != FULL) begin
                            fill_q <= fill_q + CNT_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (m_ready_i) begin
                        state_q  <= IDLE;
                        mValid_q <= 1'b0;
                        busy_q   <= 1'b0;
                        sReady_q <= 1'b1;
`ifdef FIR_SAT_EN
                        satFlag_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready_o  = sReady_q;
    assign m_valid_o  = mValid_q;
    assign m_data_o   = mData_q;
    assign busy_o     = busy_q;
`ifdef FIR_SAT_EN
    assign sat_flag_o = satFlag_q;
`endif

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine (TAPS=4, SHIFT=0) against a queue-based FIR model.
// Honours FIR_SAT_EN the same way as the design.
module tb_fir_mac_engine;

    localparam int TAPS  = 4;
    localparam int SHIFT = 0;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        coefWe    = 1'b0;
    logic [1:0]  coefAddr  = '0;
    logic [15:0] coefWdata = '0;
    logic        sValid    = 1'b0;
    logic [15:0] sData     = '0;
    logic        mReady    = 1'b0;
    logic        sReady;
    logic        mValid;
    logic [15:0] mData;
    logic        busy;
`ifdef FIR_SAT_EN
    logic        satFlag;
`endif

    int total = 0;
    int bad   = 0;

    shortint modelCoef [TAPS];
    shortint modelHist [$];

    fir_mac_engine #(
        .DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(16), .SHIFT(SHIFT)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .coef_we_i(coefWe),
        .coef_addr_i(coefAddr),
        .coef_wdata_i(coefWdata),
        .s_valid_i(sValid),
        .s_ready_o(sReady),
        .s_data_i(sData),
        .m_valid_o(mValid),
        .m_ready_i(mReady),
        .m_data_o(mData),
`ifdef FIR_SAT_EN
        .sat_flag_o(satFlag),
`endif
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Reference: y = sum of coef[k] * x[n-k] over the samples seen since reset, then shift and reduce.
    function automatic longint modelSum();
        longint acc = 0;
        for (int k = 0; k < modelHist.size(); k++) begin
            acc += longint'(modelCoef[k]) * longint'(modelHist[k]);
        end
        return acc >>> SHIFT;
    endfunction

    function automatic logic [15:0] predict();
        longint v = modelSum();
`ifdef FIR_SAT_EN
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`endif
        return v[15:0];
    endfunction

    function automatic logic predictSat();
        longint v = modelSum();
        return (v > 32767) || (v < -32768);
    endfunction

    task automatic modelPush(input logic [15:0] x);
        modelHist.push_front(shortint'(x));
        if (modelHist.size() > TAPS) void'(modelHist.pop_back());
    endtask

    task automatic holdReset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelHist.delete();
    endtask

    task automatic writeCoef(input int k, input logic [15:0] v);
        coefWe    = 1'b1;
        coefAddr  = 2'(k);
        coefWdata = v;
        @(posedge clk);
        #1;
        coefWe    = 1'b0;
        modelCoef[k] = shortint'(v);
    endtask

    task automatic waitReady();
        int n = 0;
        while (!sReady && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!mValid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] x, output int lat);
        waitReady();
        sValid = 1'b1;
        sData  = x;
        @(posedge clk);
        #1;
        sValid = 1'b0;
        modelPush(x);
        waitResult(lat);
    endtask

    task automatic popResult(output logic [15:0] d);
        d      = mData;
        mReady = 1'b1;
        @(posedge clk);
        #1;
        mReady = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%b want=0", mValid); end
        total++; if (sReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_ready got=%b want=0", sReady); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (mData !== 16'h0000) begin bad++; $display("[TB] FAIL reset_m_data got=%h want=0000", mData); end
        rst_n = 1'b1;
        modelHist.delete();
        @(posedge clk);
        #1;
        total++; if (sReady !== 1'b1) begin bad++; $display("[TB] FAIL idle_s_ready got=%b want=1", sReady); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_impulse();
        logic [15:0] samples [5] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [15:0] d, exp;
        int lat;
        for (int k = 0; k < TAPS; k++) writeCoef(k, 16'(k + 1));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(samples[i], lat);
            exp = predict();
            total++; if (lat !== TAPS + 1) begin bad++; $display("[TB] FAIL impulse_latency[%0d] got=%0d want=%0d", i, lat, TAPS + 1); end
            popResult(d);
            total++; if (d !== exp) begin bad++; $display("[TB] FAIL impulse_data[%0d] got=%h want=%h", i, d, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d, exp;
        int lat;
        holdReset(2);
        applyStimulus(16'd1, lat);
        popResult(d);
        applyStimulus(16'd0, lat);
        exp = predict();
        for (int c = 0; c < 6; c++) begin
            sValid = 1'b1;
            sData  = 16'($urandom());
            total++; if (mData !== exp) begin bad++; $display("[TB] FAIL stall_data[%0d] got=%h want=%h", c, mData, exp); end
            total++; if (mValid !== 1'b1) begin bad++; $display("[TB] FAIL stall_m_valid[%0d] got=%b want=1", c, mValid); end
            total++; if (sReady !== 1'b0) begin bad++; $display("[TB] FAIL stall_s_ready[%0d] got=%b want=0", c, sReady); end
            @(posedge clk);
            #1;
        end
        sValid = 1'b0;
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL stall_release got=%h want=%h", d, exp); end
        total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL stall_drop_valid got=%b want=0", mValid); end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'd0, lat);
            exp = predict();
            popResult(d);
            total++; if (d !== exp) begin bad++; $display("[TB] FAIL after_stall[%0d] got=%h want=%h", i, d, exp); end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d, exp;
        logic expSat;
        int lat;
        holdReset(2);
        for (int k = 0; k < TAPS; k++) writeCoef(k, 16'h7FFF);
        applyStimulus(16'h7FFF, lat);
        exp    = predict();
        expSat = predictSat();
`ifdef FIR_SAT_EN
        total++; if (satFlag !== expSat) begin bad++; $display("[TB] FAIL sat_flag_pos got=%b want=%b", satFlag, expSat); end
`endif
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL sat_pos got=%h want=%h", d, exp); end
    endtask

    task automatic test_negative();
        logic [15:0] d, exp;
        logic expSat;
        int lat;
        holdReset(2);
        writeCoef(0, 16'hFFFF);
        for (int k = 1; k < TAPS; k++) writeCoef(k, 16'h0000);
        applyStimulus(16'h8000, lat);
        exp    = predict();
        expSat = predictSat();
`ifdef FIR_SAT_EN
        total++; if (satFlag !== expSat) begin bad++; $display("[TB] FAIL sat_flag_neg got=%b want=%b", satFlag, expSat); end
`endif
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL negative got=%h want=%h", d, exp); end
    endtask

    task automatic test_coef_in_mac();
        logic [15:0] d, exp;
        int lat;
        holdReset(2);
        for (int k = 0; k < TAPS; k++) writeCoef(k, 16'(k + 1));
        waitReady();
        sValid = 1'b1;
        sData  = 16'd1;
        @(posedge clk);
        #1;
        sValid = 1'b0;
        modelPush(16'd1);
        @(posedge clk);
        #1;
        coefWe    = 1'b1;
        coefAddr  = 2'd0;
        coefWdata = 16'd100;
        @(posedge clk);
        #1;
        coefWe = 1'b0;
        waitResult(lat);
        exp = predict();
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL coef_mac_result got=%h want=%h", d, exp); end
        holdReset(2);
        applyStimulus(16'd1, lat);
        exp = predict();
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL coef_readback got=%h want=%h", d, exp); end
        // A coefficient write and a sample accepted in the same idle cycle: the new tap applies.
        waitReady();
        coefWe    = 1'b1;
        coefAddr  = 2'd1;
        coefWdata = 16'd50;
        sValid    = 1'b1;
        sData     = 16'd2;
        @(posedge clk);
        #1;
        coefWe = 1'b0;
        sValid = 1'b0;
        modelCoef[1] = 16'sd50;
        modelPush(16'd2);
        waitResult(lat);
        exp = predict();
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL coef_same_cycle got=%h want=%h", d, exp); end
    endtask

    task automatic test_reset_mid_mac();
        logic [15:0] d, exp;
        int lat;
        holdReset(2);
        for (int k = 0; k < TAPS; k++) writeCoef(k, 16'd1);
        applyStimulus(16'd7, lat);
        popResult(d);
        applyStimulus(16'd9, lat);
        popResult(d);
        waitReady();
        sValid = 1'b1;
        sData  = 16'd3;
        @(posedge clk);
        #1;
        sValid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_m_valid got=%b want=0", mValid); end
        total++; if (sReady !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_s_ready got=%b want=0", sReady); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_busy got=%b want=0", busy); end
        total++; if (mData !== 16'h0000) begin bad++; $display("[TB] FAIL mid_reset_m_data got=%h want=0000", mData); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelHist.delete();
        applyStimulus(16'd5, lat);
        exp = predict();
        total++; if (lat !== TAPS + 1) begin bad++; $display("[TB] FAIL mid_reset_latency got=%0d want=%0d", lat, TAPS + 1); end
        popResult(d);
        total++; if (d !== exp) begin bad++; $display("[TB] FAIL mid_reset_result got=%h want=%h", d, exp); end
    endtask

    task automatic test_random();
        logic [15:0] d, exp, x;
        int lat;
        holdReset(2);
        for (int k = 0; k < TAPS; k++) writeCoef(k, 16'($urandom()));
        for (int i = 0; i < 12; i++) begin
            x = 16'($urandom());
            applyStimulus(x, lat);
            exp = predict();
            total++; if (lat !== TAPS + 1) begin bad++; $display("[TB] FAIL random_latency[%0d] got=%0d want=%0d", i, lat, TAPS + 1); end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            popResult(d);
            total++; if (d !== exp) begin bad++; $display("[TB] FAIL random_data[%0d] x=%h got=%h want=%h", i, x, d, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_backpressure();
        test_saturation();
        test_negative();
        test_coef_in_mac();
        test_reset_mid_mac();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
